// File: rtl/uart_word_rx.sv
// uart_word_rx: UART receiver and 16-bit word assembler for the display path.
//   The 8N1 receiver rebuilds bytes and pairs them (low byte first) into o_word.
//   o_word feeds the 7-segment NUM input. It holds its value until the next
//   complete pair arrives.
//   If a low byte waits more than TIMEOUT_BITS idle bit-times, it is dropped.
//   The next byte is then taken as a new low byte.
// Build option: define UART_WORD_RX_PARITY_EN to receive 8E1 frames (even parity checked).
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_rst_n        asynchronous active-low reset
//   i_rx           serial input, idle high, asynchronous to i_clk
//   o_word[15:0]   last assembled word {high, low}
//   o_word_valid   1-cycle pulse when o_word updates
//   o_byte[7:0]    last received byte
//   o_byte_valid   1-cycle pulse when o_byte updates
//   o_frame_err    1-cycle pulse: bad stop (or parity), byte discarded
//   o_busy         high while the receive FSM is not idle
//
// state   | meaning
// IDLE    | line idle, waiting for a low level on the synchronised input
// START   | confirming the start bit at mid-bit
// DATA    | sampling 8 data bits, LSB first
// PARITY  | sampling the even-parity bit (parity build only)
// STOP    | sampling the stop bit, accepting or rejecting the byte

module uart_word_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx,
    output logic [15:0] o_word,
    output logic        o_word_valid,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int CPB     = CLK_FREQ / BAUD;
    localparam int HALF    = CPB / 2;
    localparam int TO_TERM = TIMEOUT_BITS * CPB;
    localparam int CW      = $clog2(CPB) + 1;
    localparam int TW      = $clog2(TO_TERM) + 1;
    localparam int BW      = $clog2(8) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_WORD_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic            r_armed;
    logic [CW-1:0]   r_clk_cnt;
    logic [BW-1:0]   r_bit_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_low;
    logic            r_ptr_high;
    logic            w_cnt_clr;
    logic            w_sample;
    logic            w_stop_ok;
    logic            w_stop_bad;
    logic            w_par_bad;
`ifdef UART_WORD_RX_PARITY_EN
    logic            r_par_err;
    logic            w_par_sample;
    assign w_par_bad = r_par_err;
`else
    assign w_par_bad = 1'b0;
`endif

    assign o_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_sample    = 1'b0;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // r_armed blocks re-entry while a break is still holding the line low
                if (!r_rx_s && r_armed) begin
                    w_state_nxt = S_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_START: begin
                if (r_clk_cnt == CW'(HALF - 1)) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_clk_cnt == CW'(CPB - 1)) begin
                    w_cnt_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_bit_cnt == BW'(7)) begin
`ifdef UART_WORD_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_WORD_RX_PARITY_EN
            S_PARITY: begin
                if (r_clk_cnt == CW'(CPB - 1)) begin
                    w_cnt_clr    = 1'b1;
                    w_par_sample = 1'b1;
                    w_state_nxt  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_clk_cnt == CW'(CPB - 1)) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                    if (r_rx_s && !w_par_bad) w_stop_ok  = 1'b1;
                    else                      w_stop_bad = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_armed      <= 1'b1;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_shift      <= '0;
            r_low        <= '0;
            r_ptr_high   <= 1'b0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_s       <= r_rx_meta;
            o_word_valid <= 1'b0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;

            if (w_cnt_clr)               r_clk_cnt <= '0;
            else if (r_state != S_IDLE)  r_clk_cnt <= r_clk_cnt + 1'b1;

            if (r_state == S_IDLE)       r_bit_cnt <= '0;
            else if (w_sample)           r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_sample) r_shift <= {r_rx_s, r_shift[7:1]};

`ifdef UART_WORD_RX_PARITY_EN
            if (r_state == S_IDLE)  r_par_err <= 1'b0;
            else if (w_par_sample)  r_par_err <= ^{r_shift, r_rx_s};
`endif

            if (w_stop_bad && !r_rx_s) r_armed <= 1'b0;
            else if (r_rx_s)           r_armed <= 1'b1;

            // Timeout and byte acceptance are exclusive: one needs IDLE, the other STOP
            if (r_ptr_high && r_state == S_IDLE) begin
                if (r_to_cnt == TW'(TO_TERM - 1)) begin
                    r_to_cnt   <= '0;
                    r_ptr_high <= 1'b0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end

            if (w_stop_ok) begin
                o_byte       <= r_shift;
                o_byte_valid <= 1'b1;
                if (r_ptr_high) begin
                    o_word       <= {r_shift, r_low};
                    o_word_valid <= 1'b1;
                    r_ptr_high   <= 1'b0;
                end else begin
                    r_low      <= r_shift;
                    r_ptr_high <= 1'b1;
                end
            end else if (w_stop_bad) begin
                o_frame_err <= 1'b1;
                r_ptr_high  <= 1'b0;
            end
        end
    end

endmodule
